rmm2ec_arb: RTL and testbench

Round-robin arbiter and response buffer that shares one 2-bit reconfigurable multiply / exponent-compare unit between `NUM_REQ` requesters inside the reconfigurable MAC.
- Each cycle it grants at most one requester, drives the shared unit's operand ports with that requester's operands, and registers the unit's combinational result into that requester's response slot.
- It sits between the MAC lane controllers (requesters) and the single shared mantissa-multiply / exponent-max resource.

---
 rtl/rmm2ec_arb_if.sv | 24 ++
 rtl/rmm2ec_arb.sv | 146 ++++++++++++++
 tb/tb_rmm2ec_arb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rmm2ec_arb_if.sv
// Requester-side bundle for rmm2ec_arb: request handshake plus per-requester response slots.
// slave = arbiter side, master = requester (lane controller) side.
interface rmm2ec_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_op;     // 0 = MUL, 1 = EXP
    logic [2*NUM_REQ-1:0] req_a;
    logic [2*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [6*NUM_REQ-1:0] rsp_data;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rmm2ec_arb.sv
// rmm2ec_arb: shares one combinational 2-bit multiply / exponent-compare unit
// between NUM_REQ requesters. At most one grant per cycle; the unit result is
// registered into the granted requester's response slot.
// Optional build macro RMM_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin.

// One response slot: captures the unit result on grant, releases on consume.
module rmm2ec_arb_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       gnt,
    input  logic       op,
    input  logic [3:0] pp,
    input  logic [1:0] emax,
    input  logic [1:0] oe1,
    input  logic [1:0] oe2,
    input  logic       rsp_ready,
    output logic       rsp_valid,
    output logic [5:0] rsp_data
);
    // Grant wins over consume so a back-to-back op keeps the slot full with fresh data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 6'd0;
        end else if (gnt) begin
            rsp_valid <= 1'b1;
            rsp_data  <= op ? {emax, oe1, oe2} : {2'b00, pp};
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

module rmm2ec_arb #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    rmm2ec_arb_if.slave      bus,
    output logic [1:0]       unit_a,
    output logic [1:0]       unit_b,
    input  logic [3:0]       unit_pp,
    input  logic [1:0]       unit_emax,
    input  logic [1:0]       unit_oe1,
    input  logic [1:0]       unit_oe2,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    logic [NUM_REQ-1:0]      elig;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [NUM_REQ-1:0][5:0] rsp_data_q;

    // A requester may be granted only if its slot is empty or being drained now.
    // Nothing is eligible while reset is asserted.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = bus.req_valid[i] & (~rsp_valid_q[i] | bus.rsp_ready[i]);
        if (rst)
            elig = '0;
    end

`ifdef RMM_ARB_FIXED_PRIO_EN
    // Fixed priority: isolate the lowest set eligibility bit.
    always_comb begin
        gnt = elig & (~elig + NUM_REQ'(1));
    end
`else
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;

    // Round-robin: scan from ptr+1 wrapping around; first eligible wins.
    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx[PTR_W-1:0];
            end
        end
    end

    // Pointer remembers the last winner; reset value makes requester 0 win first.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= PTR_W'(NUM_REQ - 1);
        else if (|gnt)
            ptr <= gnt_idx;
    end
`endif

    assign bus.req_ready = gnt;
    assign busy          = |gnt;

    // Operand mux onto the shared unit; gnt is one-hot or zero, idle drives 0.
    always_comb begin
        unit_a = 2'b00;
        unit_b = 2'b00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                unit_a = bus.req_a[2*i +: 2];
                unit_b = bus.req_b[2*i +: 2];
            end
        end
    end

    // Per-requester response slots.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        rmm2ec_arb_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .gnt       (gnt[i]),
            .op        (bus.req_op[i]),
            .pp        (unit_pp),
            .emax      (unit_emax),
            .oe1       (unit_oe1),
            .oe2       (unit_oe2),
            .rsp_ready (bus.rsp_ready[i]),
            .rsp_valid (rsp_valid_q[i]),
            .rsp_data  (rsp_data_q[i])
        );
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // Granted-operation counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            op_count <= '0;
        else if (busy && (op_count != '1))
            op_count <= op_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_rmm2ec_arb.sv
// Directed bench for rmm2ec_arb (NUM_REQ=4, CNT_W=4 so saturation is reachable).
// Inputs change #1 after the rising edge; outputs are sampled before the next edge.
module tb_rmm2ec_arb;
    localparam int NR = 4;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    unit_a, unit_b;
    logic [3:0]    unit_pp;
    logic [1:0]    unit_emax, unit_oe1, unit_oe2;
    logic          busy;
    logic [CW-1:0] op_count;

    int n_chk = 0;
    int n_err = 0;

    rmm2ec_arb_if #(.NUM_REQ(NR)) bus ();

    rmm2ec_arb #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .unit_pp   (unit_pp),
        .unit_emax (unit_emax),
        .unit_oe1  (unit_oe1),
        .unit_oe2  (unit_oe2),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Shared unit behaviour: product, max, and distances to the max.
    always_comb begin
        unit_pp   = {2'b00, unit_a} * {2'b00, unit_b};
        unit_emax = (unit_a > unit_b) ? unit_a : unit_b;
        unit_oe1  = unit_emax - unit_a;
        unit_oe2  = unit_emax - unit_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        tick();
        tick();

        // Reset state; requests are ignored while rst is high.
        bus.req_valid = 4'hF;
        bus.req_a     = 8'hFF;
        bus.req_b     = 8'hFF;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_busy",  32'(busy),          32'h0);
        chk("rst_unit_a", 32'(unit_a),       32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
        chk("rst_op_count",  32'(op_count),      32'h0);

        // MUL on requester 0: 3*3 = 9.
        rst           = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_op    = 4'b0000;
        bus.req_a     = 8'h03;
        bus.req_b     = 8'h03;
        bus.rsp_ready = 4'hF;
        #1;
        chk("mul_ready",  32'(bus.req_ready), 32'h1);
        chk("mul_unit_a", 32'(unit_a),        32'h3);
        chk("mul_unit_b", 32'(unit_b),        32'h3);
        chk("mul_busy",   32'(busy),          32'h1);
        tick();
        bus.req_valid = '0;
        chk("mul_rsp_valid", 32'(bus.rsp_valid),     32'h1);
        chk("mul_rsp_data",  32'(bus.rsp_data[5:0]), 32'b001001);
        chk("mul_op_count",  32'(op_count),          32'h1);

        // EXP on requester 2: a=1, b=3 -> emax=3, oe1=2, oe2=0.
        bus.req_valid = 4'b0100;
        bus.req_op    = 4'b0100;
        bus.req_a     = 8'h10;
        bus.req_b     = 8'h30;
        #1;
        chk("exp_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        chk("exp_rsp_data",  32'(bus.rsp_data[17:12]), 32'b111000);
        chk("exp_rsp_valid", 32'(bus.rsp_valid),       32'h4);
        chk("exp_op_count",  32'(op_count),            32'h2);
        tick();

        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.req_op    = '0;
        bus.rsp_ready = 4'hF;
`ifndef RMM_ARB_FIXED_PRIO_EN
        // Round-robin with everyone eligible: 0,1,2,3,0,1.
        bus.req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            logic [3:0] e;
            e = 4'b0001 << (c % 4);
            #1;
            chk("rr_grant", 32'(bus.req_ready), 32'(e));
            chk("rr_busy",  32'(busy),          32'h1);
            tick();
        end
`else
        // Fixed priority: requester 0 always beats requester 1.
        bus.req_valid = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("fp_grant", 32'(bus.req_ready), 32'h1);
            chk("fp_busy",  32'(busy),          32'h1);
            tick();
        end
`endif
        bus.req_valid = '0;
        chk("arb_op_count", 32'(op_count), 32'h6);

        // Backpressure: fill slot 1 and hold it.
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.rsp_ready = '0;
        bus.req_valid = 4'b0010;
        bus.req_op    = '0;
        bus.req_a     = 8'h08;   // a1=2
        bus.req_b     = 8'h0C;   // b1=3
        #1;
        chk("bp_fill", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b0011;
        bus.req_a     = 8'h06;   // a1=1, a0=2
        bus.req_b     = 8'h06;   // b1=1, b0=2
        #1;
        chk("bp_skip", 32'(bus.req_ready), 32'h1);
        tick();
        chk("bp_hold_data", 32'(bus.rsp_data[11:6]), 32'b000110);
        chk("bp_req0_data", 32'(bus.rsp_data[5:0]),  32'b000100);
        chk("bp_rsp_valid", 32'(bus.rsp_valid),      32'h3);
        bus.rsp_ready = 4'b0010;
        #1;
        chk("bp_release", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        chk("bp_new_data",  32'(bus.rsp_data[11:6]), 32'b000001);
        chk("bp_rsp_valid2", 32'(bus.rsp_valid),     32'h3);
        chk("bp_op_count",  32'(op_count),           32'h3);

        // Build rsp_valid=1011, op_count=7, then reset mid-operation.
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 4'hF;
        repeat (4) tick();
        bus.req_valid = 4'b1011;
        bus.rsp_ready = 4'b0100;
        repeat (3) tick();
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'hB);
        chk("mid_op_count",  32'(op_count),      32'h7);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        chk("mid_rst_busy",  32'(busy),          32'h0);
        tick();
        rst           = 1'b0;
        bus.rsp_ready = '0;
        chk("post_rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("post_rst_data",  32'(bus.rsp_data),  32'h0);
        chk("post_rst_count", 32'(op_count),      32'h0);
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
        tick();

        // Counter saturation at all-ones; one op per cycle with rsp_ready held.
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 4'hF;
        repeat (14) tick();
        chk("sat_14", 32'(op_count), 32'd14);
        tick();
        chk("sat_15", 32'(op_count), 32'd15);
        repeat (3) tick();
        chk("sat_hold", 32'(op_count), 32'd15);
        chk("sat_busy", 32'(busy),     32'h1);
        bus.req_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
